// File: rtl/mgmt_rx_frame_reader_if.sv
// Host/FIFO-facing signal bundle for the management RX frame reader.
// master is the reader's view; slave is the view of the FIFOs and host around it.
interface mgmt_rx_frame_reader_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned DATA_W = 32;

  logic                 rxheader_rd_empty;
  logic                 rxheader_rd_en;
  logic [LEN_W-1:0]     rxheader_rd_data;
  logic                 rxfifo_rd_en;
  logic                 rxfifo_rd_pop_single;
  logic [DATA_W-1:0]    rxfifo_rd_data;
  logic                 frame_valid;
  logic [LEN_W-1:0]     frame_len;
  logic                 frame_start;
  logic                 frame_discard;
  logic                 word_valid;
  logic                 word_ready;
  logic [DATA_W-1:0]    word_data;
  logic                 word_last;
  logic [CNT_WIDTH-1:0] discard_count;

  modport master (
    input  rxheader_rd_empty, rxheader_rd_data, rxfifo_rd_data,
           frame_start, frame_discard, word_ready,
    output rxheader_rd_en, rxfifo_rd_en, rxfifo_rd_pop_single,
           frame_valid, frame_len, word_valid, word_data, word_last, discard_count
  );

  modport slave (
    output rxheader_rd_empty, rxheader_rd_data, rxfifo_rd_data,
           frame_start, frame_discard, word_ready,
    input  rxheader_rd_en, rxfifo_rd_en, rxfifo_rd_pop_single,
           frame_valid, frame_len, word_valid, word_data, word_last, discard_count
  );
endinterface

// File: rtl/mgmt_rx_frame_reader.sv
// Pops frame lengths from the header FIFO, then streams or discards that many
// data words from the data FIFO under host control, one read in flight at a time.
module mgmt_rx_frame_reader #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  mgmt_rx_frame_reader_if.master bus
);
  localparam int unsigned LEN_W  = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WL_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_RD, S_HDR_LATCH, S_PENDING, S_STREAM, S_DISCARD
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     frame_len_q, frame_len_d;
  logic [WL_W-1:0]      words_left_q, words_left_d;
  logic                 in_flight_q, in_flight_d;
  logic                 last_flight_q, last_flight_d;
  logic                 word_valid_q, word_valid_d;
  logic [DATA_W-1:0]    word_data_q, word_data_d;
  logic                 word_last_q, word_last_d;
  logic [CNT_WIDTH-1:0] discard_count_q, discard_count_d;
  logic                 hdr_rd_en_q, hdr_rd_en_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 issue_c, drop_pop_c, accept_c;

  assign accept_c = word_valid_q & bus.word_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (!bus.rxheader_rd_empty) state_d = S_HDR_RD;
      S_HDR_RD:    state_d = S_HDR_LATCH;
      S_HDR_LATCH: state_d = S_PENDING;
      S_PENDING: begin
        // discard has priority over a simultaneous start
        if (bus.frame_discard)    state_d = S_DISCARD;
        else if (bus.frame_start) state_d = (words_left_q == '0) ? S_IDLE : S_STREAM;
      end
      S_STREAM: begin
        if (bus.frame_discard)            state_d = S_DISCARD;
        else if (accept_c && word_last_q) state_d = S_IDLE;
      end
      S_DISCARD:   if (words_left_q == '0) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_c         = 1'b0;
    drop_pop_c      = 1'b0;
    frame_len_d     = frame_len_q;
    words_left_d    = words_left_q;
    in_flight_d     = in_flight_q;
    last_flight_d   = last_flight_q;
    word_valid_d    = word_valid_q;
    word_data_d     = word_data_q;
    word_last_d     = word_last_q;
    discard_count_d = discard_count_q;
    unique case (state_q)
      S_HDR_LATCH: begin
        frame_len_d  = bus.rxheader_rd_data;
        words_left_d = WL_W'((32'(bus.rxheader_rd_data) + 32'd3) >> 2);
      end
      S_STREAM: begin
        if (bus.frame_discard) begin
          word_valid_d = 1'b0;
          word_last_d  = 1'b0;
          in_flight_d  = 1'b0;
        end else begin
          if (accept_c) begin
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
          end
          if (in_flight_q) begin
            word_valid_d = 1'b1;
            word_data_d  = bus.rxfifo_rd_data;
            word_last_d  = last_flight_q;
            in_flight_d  = 1'b0;
          end
          // a new read only once the previous word has left the output register
          if ((words_left_q != '0) && !in_flight_q && (!word_valid_q || accept_c)) begin
            issue_c       = 1'b1;
            in_flight_d   = 1'b1;
            last_flight_d = (words_left_q == WL_W'(1));
            words_left_d  = words_left_q - WL_W'(1);
          end
        end
      end
      S_DISCARD: begin
        if (words_left_q != '0) begin
          drop_pop_c   = 1'b1;
          words_left_d = words_left_q - WL_W'(1);
        end else begin
          discard_count_d = discard_count_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
    hdr_rd_en_d   = (state_d == S_HDR_RD);
    frame_valid_d = (state_d == S_PENDING) || (state_d == S_STREAM);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_len_q     <= '0;
      words_left_q    <= '0;
      in_flight_q     <= 1'b0;
      last_flight_q   <= 1'b0;
      word_valid_q    <= 1'b0;
      word_data_q     <= '0;
      word_last_q     <= 1'b0;
      discard_count_q <= '0;
      hdr_rd_en_q     <= 1'b0;
      frame_valid_q   <= 1'b0;
    end else begin
      frame_len_q     <= frame_len_d;
      words_left_q    <= words_left_d;
      in_flight_q     <= in_flight_d;
      last_flight_q   <= last_flight_d;
      word_valid_q    <= word_valid_d;
      word_data_q     <= word_data_d;
      word_last_q     <= word_last_d;
      discard_count_q <= discard_count_d;
      hdr_rd_en_q     <= hdr_rd_en_d;
      frame_valid_q   <= frame_valid_d;
    end
  end

  // read strobes follow the host handshake in the same cycle; reset kills them at once
  assign bus.rxfifo_rd_en         = issue_c & ~sys_rst;
  assign bus.rxfifo_rd_pop_single = (issue_c | drop_pop_c) & ~sys_rst;
  assign bus.rxheader_rd_en       = hdr_rd_en_q;
  assign bus.frame_valid          = frame_valid_q;
  assign bus.frame_len            = frame_len_q;
  assign bus.word_valid           = word_valid_q;
  assign bus.word_data            = word_data_q;
  assign bus.word_last            = word_last_q;
  assign bus.discard_count        = discard_count_q;
endmodule
